// File: rtl/fru_config_sequencer_pkg.sv
// fru_config_sequencer_pkg: shared state encoding, idle bus ID and payload-length helper
package fru_config_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, SEND, POST} state_t;
  localparam logic [7:0] IDLE_CONFIG_ID = 8'hFF;
  function automatic int unsigned payload_bytes(input int unsigned max_chains, input int unsigned fuvrf_size,
                                                input int unsigned m, input int unsigned data_width);
    return max_chains * 3 + fuvrf_size * m * data_width / 8;
  endfunction
endpackage

// File: rtl/fru_config_sequencer_if.sv
// fru_config_sequencer_if: host byte stream, config bus and status bundle
interface fru_config_sequencer_if #(parameter int CNT_W = 9);
  logic start;
  logic [7:0] unit_id;
  logic [CNT_W-1:0] byte_count;
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic stall_out;
  logic tracing;
  logic [7:0] configId;
  logic [7:0] configData;
  logic busy;
  logic done;
  logic err;
  modport master (output start, unit_id, byte_count, byte_in, byte_valid,
                  input byte_ready, stall_out, tracing, configId, configData, busy, done, err);
  modport slave (input start, unit_id, byte_count, byte_in, byte_valid,
                 output byte_ready, stall_out, tracing, configId, configData, busy, done, err);
endinterface

// File: rtl/fru_config_sequencer_config_byte_buffer.sv
// fru_config_sequencer_config_byte_buffer: simple dual-port byte store with 1-cycle registered read
module fru_config_sequencer_config_byte_buffer #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);
  logic [7:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end
  // read port idles at zero so it can drive the config data bus directly
  always_ff @(posedge clk) begin
    if (!rst_n) o_rd_data <= '0;
    else o_rd_data <= i_rd_en ? r_mem[i_rd_addr] : 8'h00;
  end
endmodule

// File: rtl/fru_config_sequencer.sv
// fru_config_sequencer: buffers a host payload, then stalls, drains and streams it
// contiguously onto the configId/configData bus while owning the tracing signal
module fru_config_sequencer import fru_config_sequencer_pkg::*; #(
  parameter int MAX_BYTES = 256,
  parameter int DRAIN_CYCLES = 4,
  parameter int POST_CYCLES = 2,
  parameter int CNT_W = $clog2(MAX_BYTES + 1)
) (
  input logic clk,
  input logic rst_n,
  fru_config_sequencer_if.slave bus
);
  localparam int AW = $clog2(MAX_BYTES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_CYCLES - 1);
  state_t r_state;
  logic [7:0] r_unit, r_config_id, w_rd_data;
  logic [CNT_W-1:0] r_count, r_wr_ptr, r_rd_ptr, r_cnt;
  logic r_byte_ready, r_stall, r_tracing, r_busy, r_done, r_err;
  logic w_wr_en, w_rd_en, w_last_byte, w_len_ok;
  assign w_wr_en = r_state == LOAD && bus.byte_valid && r_byte_ready;
  assign w_last_byte = w_wr_en && r_wr_ptr == r_count - ONE;
  assign w_len_ok = bus.byte_count != '0 && bus.byte_count <= MAX_CNT;
  // buf[0] is fetched in the last drain cycle so SEND starts with data already on the bus
  assign w_rd_en = (r_state == DRAIN && r_cnt == DRAIN_LAST) || (r_state == SEND && r_rd_ptr < r_count);
  fru_config_sequencer_config_byte_buffer #(.DEPTH(MAX_BYTES)) u_config_byte_buffer (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(w_wr_en), .i_wr_addr(r_wr_ptr[AW-1:0]), .i_wr_data(bus.byte_in),
    .i_rd_en(w_rd_en), .i_rd_addr(r_rd_ptr[AW-1:0]), .o_rd_data(w_rd_data)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_unit <= '0;
      r_count <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt <= '0;
      r_config_id <= IDLE_CONFIG_ID;
      r_byte_ready <= 1'b0;
      r_stall <= 1'b0;
      r_tracing <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err <= 1'b0;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + ONE;
      case (r_state)
        IDLE: if (bus.start) begin
          if (w_len_ok) begin
            r_state <= LOAD;
            r_unit <= bus.unit_id;
            r_count <= bus.byte_count;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_byte_ready <= 1'b1;
            r_busy <= 1'b1;
          end else r_err <= 1'b1;
        end
        LOAD: if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + ONE;
          if (w_last_byte) begin
            r_state <= DRAIN;
            r_byte_ready <= 1'b0;
            r_stall <= 1'b1;
            r_cnt <= '0;
          end
        end
        DRAIN: begin
          r_cnt <= r_cnt + ONE;
          if (r_cnt == DRAIN_LAST) begin
            r_state <= SEND;
            r_tracing <= 1'b0;
            r_config_id <= r_unit;
            r_cnt <= '0;
          end
        end
        SEND: begin
          r_cnt <= r_cnt + ONE;
          if (r_cnt == r_count - ONE) begin
            r_state <= POST;
            r_config_id <= IDLE_CONFIG_ID;
            r_cnt <= '0;
          end
        end
        POST: begin
          r_cnt <= r_cnt + ONE;
          if (r_cnt == POST_LAST) begin
            r_state <= IDLE;
            r_tracing <= 1'b1;
            r_stall <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.byte_ready = r_byte_ready;
  assign bus.stall_out = r_stall;
  assign bus.tracing = r_tracing;
  assign bus.configId = r_config_id;
  assign bus.configData = w_rd_data;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err = r_err;
endmodule
